// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the Avalon-MM input PIO: register map and edge-detect modes.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum int unsigned {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

  // An edge is reported when the debounced level updates, qualified by its new value.
  function automatic logic edge_hit(input edge_type_e kind, input logic upd, input logic level);
    case (kind)
      EDGE_RISE: return upd & level;
      EDGE_FALL: return upd & ~level;
      default:   return upd;
    endcase
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: metastability synchroniser followed by a threshold debounce counter.
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pin,
  input  logic [DEBOUNCE_W-1:0] thr,
  output logic                  level,
  output logic                  sync,
  output logic                  upd
);

  logic [SYNC_STAGES-1:0] chain;
  logic [DEBOUNCE_W-1:0]  cnt;

  assign sync = chain[SYNC_STAGES-1];
  // Combinational so the edge register captures on the same clock the level flips.
  assign upd  = (sync != level) && (cnt >= thr);

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      if (sync == level) begin
        cnt <= '0;
      end else if (upd) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end
  end

endmodule

// File: rtl/soc_system_pio_in_irq.sv
// Avalon-MM input PIO: debounced pin levels, edge capture with W1C, masked level IRQ.
module soc_system_pio_in_irq
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH         = 20,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned EDGE_TYPE     = 0,
  parameter int unsigned DEBOUNCE_W    = 16,
  parameter int unsigned DEBOUNCE_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0]      level;
  logic [WIDTH-1:0]      sync;
  logic [WIDTH-1:0]      upd;
  logic [WIDTH-1:0]      edge_event;
  logic [WIDTH-1:0]      irq_mask;
  logic [WIDTH-1:0]      edge_cap;
  logic [WIDTH-1:0]      cap_clear;
  logic [DEBOUNCE_W-1:0] debounce_thr;
  logic [31:0]           rd_mux;
  logic                  wr;
  logic                  unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    soc_system_pio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .pin   (in_port[g]),
      .thr   (debounce_thr),
      .level (level[g]),
      .sync  (sync[g]),
      .upd   (upd[g])
    );
  end

  always_comb begin
    edge_event = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      edge_event[i] = edge_hit(edge_type_e'(EDGE_TYPE), upd[i], sync[i]);
    end
  end

  always_comb begin
    cap_clear = '0;
    if (wr && address == ADDR_EDGE_CAP) cap_clear = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0]      = level;
      ADDR_DEBOUNCE: rd_mux[DEBOUNCE_W-1:0] = debounce_thr;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0]      = irq_mask;
      default:       rd_mux[WIDTH-1:0]      = edge_cap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata     <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      debounce_thr <= DEBOUNCE_W'(DEBOUNCE_INIT);
    end else begin
      readdata <= rd_mux;
      // New edges are OR-ed after the clear so a coincident edge is never lost.
      edge_cap <= (edge_cap & ~cap_clear) | edge_event;
      if (wr && address == ADDR_DEBOUNCE) debounce_thr <= writedata[DEBOUNCE_W-1:0];
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_in_irq.sv
// Bench for the input PIO: three builds (rising/falling/any edge) share one bus and pin set.
module tb_soc_system_pio_in_irq;

  localparam int W  = 20;
  localparam int S  = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_W(DW), .DEBOUNCE_INIT(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r), .in_port(in_port), .irq(irq_r));
  soc_system_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1), .DEBOUNCE_W(DW), .DEBOUNCE_INIT(0)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_f), .in_port(in_port), .irq(irq_f));
  soc_system_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_W(DW), .DEBOUNCE_INIT(0)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pins delayed S cycles, a bit's level follows once it has disagreed
  // for more than thr cycles; index 0/1/2 = rising/falling/any capture.
  logic [W-1:0]  m_pipe [S];
  logic [W-1:0]  m_stable;
  int unsigned   m_run [W];
  logic [DW-1:0] m_thr;
  logic [W-1:0]  m_mask;
  logic [W-1:0]  m_cap [3];
  logic [31:0]   m_rd [3];
  logic          m_irq [3];
  bit            model_ready = 0;

  always @(posedge clk) begin
    logic [W-1:0] sync_v, upd_v, clr_v;
    logic [W-1:0] ev [3];
    logic         wr_v;
    if (reset) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_stable = '0;
      m_thr    = '0;
      m_mask   = '0;
      for (int e = 0; e < 3; e++) begin
        m_cap[e] = '0;
        m_rd[e]  = '0;
      end
      model_ready = 1;
    end else begin
      sync_v = m_pipe[S-1];
      for (int e = 0; e < 3; e++) begin
        case (address)
          2'd0: m_rd[e] = 32'(m_stable);
          2'd1: m_rd[e] = 32'(m_thr);
          2'd2: m_rd[e] = 32'(m_mask);
          default: m_rd[e] = 32'(m_cap[e]);
        endcase
      end
      upd_v = '0;
      for (int i = 0; i < W; i++) begin
        if (sync_v[i] == m_stable[i]) m_run[i] = 0;
        else if (m_run[i] >= 32'(m_thr)) begin
          upd_v[i] = 1'b1;
          m_run[i] = 0;
        end else m_run[i]++;
      end
      m_stable = m_stable ^ upd_v;
      ev[0] = upd_v & sync_v;
      ev[1] = upd_v & ~sync_v;
      ev[2] = upd_v;
      wr_v  = chipselect && !write_n;
      clr_v = (wr_v && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int e = 0; e < 3; e++) m_cap[e] = (m_cap[e] & ~clr_v) | ev[e];
      if (wr_v && address == 2'd1) m_thr  = writedata[DW-1:0];
      if (wr_v && address == 2'd2) m_mask = writedata[W-1:0];
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = in_port;
    end
    for (int e = 0; e < 3; e++) m_irq[e] = |(m_cap[e] & m_mask);
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("model_rd_rise", rd_r, m_rd[0]);
      check("model_rd_fall", rd_f, m_rd[1]);
      check("model_rd_any",  rd_a, m_rd[2]);
      check("model_irq_rise", 32'(irq_r), 32'(m_irq[0]));
      check("model_irq_fall", 32'(irq_f), 32'(m_irq[1]));
      check("model_irq_any",  32'(irq_a), 32'(m_irq[2]));
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [1:0] saved;
    saved      = address;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = saved;
  endtask

  initial begin
    #1000000;
    failed++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", rd_r, 32'h0);
    check("reset_irq", 32'(irq_r), 32'h0);

    // Rising edge with zero threshold: level and capture after S+1 clocks.
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_data_before", rd_r, 32'h0);
    @(negedge clk);
    check("t1_data", rd_r, 32'h8);
    address = 2'd3;
    @(negedge clk);
    check("t1_cap_rise", rd_r, 32'h8);
    check("t1_cap_fall", rd_f, 32'h0);
    check("t1_cap_any", rd_a, 32'h8);
    check("t1_irq_masked", 32'(irq_r), 32'h0);
    bus_write(2'd2, 32'h8);
    check("t1_irq_unmasked", 32'(irq_r), 32'h1);
    check("t1_irq_fall", 32'(irq_f), 32'h0);

    // Threshold 10: short pulse filtered, long pulse lands at S+11 clocks.
    bus_write(2'd1, 32'd10);
    address = 2'd0;
    in_port[0] = 1'b1;
    repeat (8) @(negedge clk);
    in_port[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("t2_glitch_data", rd_r, 32'h8);
    address = 2'd3;
    @(negedge clk);
    check("t2_glitch_cap", rd_r, 32'h8);
    address = 2'd0;
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (13) @(negedge clk);
    check("t2_data_before", rd_r, 32'h8);
    @(negedge clk);
    check("t2_data", rd_r, 32'h9);

    // W1C of bit 0 only; irq follows the mask.
    address = 2'd3;
    @(negedge clk);
    check("t3_cap_pre", rd_r, 32'h9);
    bus_write(2'd3, 32'h1);
    @(negedge clk);
    check("t3_cap_post", rd_r, 32'h8);
    check("t3_irq_on", 32'(irq_r), 32'h1);
    bus_write(2'd2, 32'h1);
    check("t3_irq_off", 32'(irq_r), 32'h0);

    // Clear of bit 2 on the very clock its edge arrives: bit stays set.
    bus_write(2'd1, 32'd0);
    in_port[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(2'd3, 32'h4);
    @(negedge clk);
    check("t4_cap_rise", rd_r, 32'hC);
    check("t4_cap_any", rd_a, 32'hC);
    check("t4_cap_fall", rd_f, 32'h0);

    // Edge type builds on bit 1.
    in_port[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_rise_on_fall", rd_f, 32'h0);
    check("t5_rise_on_rise", rd_r, 32'hE);
    check("t5_rise_on_any", rd_a, 32'hE);
    in_port[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_fall_on_fall", rd_f, 32'h2);
    check("t5_fall_on_any", rd_a, 32'hE);

    // Threshold lowered mid-count: update on the following clock.
    bus_write(2'd1, 32'd100);
    address = 2'd0;
    in_port[0] = 1'b0;
    repeat (52) @(negedge clk);
    bus_write(2'd1, 32'd20);
    @(negedge clk);
    check("t6_data_before", rd_r, 32'hD);
    @(negedge clk);
    check("t6_data_after", rd_r, 32'hC);

    // Reset in the middle of a count: nothing survives, nothing captured later.
    in_port[5] = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    in_port = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    address = 2'd3;
    repeat (30) @(negedge clk);
    check("t6_rst_cap_rise", rd_r, 32'h0);
    check("t6_rst_cap_fall", rd_f, 32'h0);
    check("t6_rst_irq", 32'(irq_a), 32'h0);
    address = 2'd0;
    @(negedge clk);
    check("t6_rst_data", rd_r, 32'h0);
    address = 2'd1;
    @(negedge clk);
    check("t6_rst_thr", rd_r, 32'h0);
    address = 2'd2;
    @(negedge clk);
    check("t6_rst_mask", rd_r, 32'h0);

    // Pin already high when reset releases: captured as a rising edge.
    reset = 1'b1;
    in_port[4] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    address = 2'd3;
    repeat (4) @(negedge clk);
    check("t7_cap_rise", rd_r, 32'h10);
    check("t7_cap_fall", rd_f, 32'h0);
    check("t7_cap_any", rd_a, 32'h10);
    bus_write(2'd2, 32'h10);
    check("t7_irq_rise", 32'(irq_r), 32'h1);
    check("t7_irq_fall", 32'(irq_f), 32'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
